// File: rtl/dma_pkg.sv
// dma_pkg: shared types and constants for the DMA disk sequencer.
// Holds the FSM state enum and the 1024x32 disk geometry.
package dma_pkg;

  localparam int DISK_AW    = 10;
  localparam int DISK_DW    = 32;
  localparam int DISK_WORDS = 1024;
  localparam int WORD_INC   = 4;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT_RDY,
    WRITE,
    LOAD,
    FIN
  } dma_disk_state_t;

endpackage

// File: rtl/dma_disk_wdog.sv
// dma_disk_wdog: cycle watchdog for the WAIT_RDY state.
// Used only when DMA_DISK_TIMEOUT_EN is defined.
module dma_disk_wdog #(
  parameter int LIMIT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 16'd1;
    end
  end

  // fires on the LIMIT-th enabled cycle
  assign expire = en && (cnt == 16'(LIMIT - 1));

endmodule

// File: rtl/dma_disk_ctrl.sv
// dma_disk_ctrl: disk-to-memory block copy sequencer.
// Optional d_ready watchdog under DMA_DISK_TIMEOUT_EN.
module dma_disk_ctrl
  import dma_pkg::*;
#(
  parameter int MADDR_W     = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DISK_AW-1:0] cmd_disk_addr,
  input  logic [MADDR_W-1:0] cmd_mem_addr,
  input  logic [DISK_AW-1:0] cmd_len,
  output logic               d_init,
  output logic               d_done,
  output logic [DISK_AW-1:0] d_addr,
  input  logic               d_ready,
  input  logic [DISK_DW-1:0] d_data,
  output logic               m_wr_req,
  output logic [MADDR_W-1:0] m_wr_addr,
  output logic [DISK_DW-1:0] m_wr_data,
  input  logic               m_wr_ack,
  output logic               busy,
  output logic               done,
  output logic               err
);

  dma_disk_state_t state;
  logic [10:0]     remaining;
  logic            tmo;

`ifdef DMA_DISK_TIMEOUT_EN
  dma_disk_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != WAIT_RDY),
    .en     (state == WAIT_RDY),
    .expire (tmo)
  );
`else
  logic unused_tmo;
  assign unused_tmo = ^16'(TIMEOUT_CYC);
  assign tmo = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      d_init    <= 1'b0;
      d_done    <= 1'b0;
      done      <= 1'b0;
      d_addr    <= '0;
      m_wr_req  <= 1'b0;
      m_wr_addr <= '0;
      m_wr_data <= '0;
      err       <= 1'b0;
    end else begin
      d_init <= 1'b0;
      d_done <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            d_addr    <= cmd_disk_addr;
            m_wr_addr <= cmd_mem_addr;
            // a zero length encodes a full 1024-word block
            remaining <= (cmd_len == '0) ? 11'(DISK_WORDS)
                                         : {1'b0, cmd_len};
            err       <= 1'b0;
            d_init    <= 1'b1;
            state     <= INIT;
          end
        end
        INIT: state <= WAIT_RDY;
        WAIT_RDY: begin
          if (d_ready) begin
            m_wr_data <= d_data;
            m_wr_req  <= 1'b1;
            state     <= WRITE;
          end else if (tmo) begin
            err    <= 1'b1;
            d_done <= 1'b1;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        WRITE: begin
          if (m_wr_ack) begin
            m_wr_req  <= 1'b0;
            remaining <= remaining - 11'd1;
            d_addr    <= d_addr + 1'b1;
            m_wr_addr <= m_wr_addr + MADDR_W'(WORD_INC);
            if (remaining == 11'd1) begin
              d_done <= 1'b1;
              done   <= 1'b1;
              state  <= FIN;
            end else begin
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          m_wr_data <= d_data;
          m_wr_req  <= 1'b1;
          state     <= WRITE;
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
